// File: rtl/dram_pkg.sv
// Shared types and constants for the DRAM address mapper.
package dram_pkg;

  // Classification of a request against the open-row state of its bank.
  typedef enum logic [1:0] {
    ROW_EMPTY = 2'd0,
    ROW_HIT   = 2'd1,
    ROW_MISS  = 2'd2
  } row_state_e;

  // Address mapping modes. Encoding 3 is decoded as MAP_BRC.
  localparam logic [1:0] MAP_BRC = 2'd0;  // bank:row:col
  localparam logic [1:0] MAP_RBC = 2'd1;  // row:bank:col
  localparam logic [1:0] MAP_XOR = 2'd2;  // bank:row:col, bank XOR-hashed with row

endpackage

// File: rtl/dram_addr_mapper_if.sv
// Request and decoded-output buses of the DRAM address mapper.
// The master side drives requests and sinks decoded results; the slave
// side is the mapper itself.
interface dram_addr_mapper_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int BANK_W     = 3,
  parameter int ROW_W      = 7,
  parameter int COL_W      = 3
);

  // Request side (from L2)
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] l2_req_address;

  // Decoded side (to the command scheduler)
  logic                  out_valid;
  logic                  out_ready;
  logic [BANK_W-1:0]     bank_id;
  logic [ROW_W-1:0]      row_id;
  logic [COL_W-1:0]      col_id;
  logic [1:0]            row_state;
  logic [ROW_W-1:0]      prev_row;
  logic                  addr_err;

  modport master (
    output req_valid, l2_req_address, out_ready,
    input  req_ready, out_valid, bank_id, row_id, col_id,
           row_state, prev_row, addr_err
  );

  modport slave (
    input  req_valid, l2_req_address, out_ready,
    output req_ready, out_valid, bank_id, row_id, col_id,
           row_state, prev_row, addr_err
  );

endinterface

// File: rtl/dram_open_row_table.sv
// Per-bank open-row table. The lookup port already reflects a precharge
// presented in the same cycle, so a request racing a precharge of its own
// bank sees the bank as closed. A write in the same cycle as a precharge of
// the same bank wins, leaving the freshly opened row valid.
module dram_open_row_table #(
  parameter  int NUM_OF_BANKS = 8,
  parameter  int ROW_W        = 7,
  localparam int BANK_W       = $clog2(NUM_OF_BANKS)
) (
  input  logic              clk,
  input  logic              rst,
  // lookup
  input  logic [BANK_W-1:0] lookup_bank,
  output logic              lookup_valid,
  output logic [ROW_W-1:0]  lookup_row,
  // write (row opened by an accepted request)
  input  logic              wr_en,
  input  logic [BANK_W-1:0] wr_bank,
  input  logic [ROW_W-1:0]  wr_row,
  // precharge
  input  logic              pre_valid,
  input  logic              pre_all,
  input  logic [BANK_W-1:0] pre_bank
);

  logic [NUM_OF_BANKS-1:0] valid_q;
  logic [ROW_W-1:0]        row_q [NUM_OF_BANKS];
  logic                    pre_hits_lookup;

  assign pre_hits_lookup = pre_valid && (pre_all || (pre_bank == lookup_bank));
  assign lookup_valid    = valid_q[lookup_bank] && !pre_hits_lookup;
  assign lookup_row      = row_q[lookup_bank];

  // Valid bits: precharge clears, a same-cycle write to the bank re-sets.
  // NOTE: state is written with <= so every bit reads the pre-edge value;
  // the later write to valid_q[b] in the same pass intentionally overrides.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      for (int b = 0; b < NUM_OF_BANKS; b++) begin
        if (pre_valid && (pre_all || (pre_bank == BANK_W'(b)))) valid_q[b] <= 1'b0;
        if (wr_en && (wr_bank == BANK_W'(b)))                    valid_q[b] <= 1'b1;
      end
    end
  end

  // Row storage, written on every accepted request.
  // NOTE: the row array has no reset; its contents are only ever read
  // when the matching valid bit is set, and valid_q is reset.
  always_ff @(posedge clk) begin
    if (wr_en) row_q[wr_bank] <= wr_row;
  end

endmodule

// File: rtl/dram_addr_mapper.sv
// DRAM address mapper: splits an L2 request address into bank/row/col
// according to map_mode, classifies it against the open-row table and
// presents the result one cycle later behind a valid/ready register.
module dram_addr_mapper
  import dram_pkg::*;
#(
  parameter  int ADDR_WIDTH   = 13,
  parameter  int NUM_OF_BANKS = 8,
  parameter  int NUM_OF_ROWS  = 128,
  parameter  int NUM_OF_COLS  = 8,
  localparam int BANK_W       = $clog2(NUM_OF_BANKS),
  localparam int ROW_W        = $clog2(NUM_OF_ROWS),
  localparam int COL_W        = $clog2(NUM_OF_COLS),
  localparam int USED_W       = BANK_W + ROW_W + COL_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          map_mode,
  input  logic                pre_valid,
  input  logic                pre_all,
  input  logic [BANK_W-1:0]   pre_bank,
  dram_addr_mapper_if.slave   bus
);

  logic              accept;
  logic              out_valid_q;

  logic [BANK_W-1:0] bank_raw;
  logic [BANK_W-1:0] bank_d;
  logic [ROW_W-1:0]  row_d;
  logic [COL_W-1:0]  col_d;
  logic              addr_err_d;

  logic              lk_valid;
  logic [ROW_W-1:0]  lk_row;
  row_state_e        state_d;
  logic [ROW_W-1:0]  prev_d;

  logic [BANK_W-1:0] bank_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  row_state_e        state_q;
  logic [ROW_W-1:0]  prev_q;
  logic              addr_err_q;

  // A new request can enter whenever the output slot is empty or draining.
  assign bus.req_ready = !out_valid_q || bus.out_ready;
  assign accept        = bus.req_valid && bus.req_ready;

  // Field extraction for the selected mapping mode.
  // NOTE: every always_comb output gets a default first so no path can
  // infer a latch.
  always_comb begin
    col_d    = bus.l2_req_address[COL_W-1:0];
    row_d    = bus.l2_req_address[COL_W +: ROW_W];
    bank_raw = bus.l2_req_address[COL_W+ROW_W +: BANK_W];
    bank_d   = bank_raw;
    case (map_mode)
      MAP_RBC: begin
        bank_d = bus.l2_req_address[COL_W +: BANK_W];
        row_d  = bus.l2_req_address[COL_W+BANK_W +: ROW_W];
      end
      MAP_XOR: bank_d = bank_raw ^ row_d[BANK_W-1:0];
      default: ;
    endcase
  end

  // Upper address bits beyond the mapped fields flag an out-of-range request.
  if (USED_W < ADDR_WIDTH) begin : g_addr_err
    assign addr_err_d = |bus.l2_req_address[ADDR_WIDTH-1:USED_W];
  end else begin : g_no_addr_err
    assign addr_err_d = 1'b0;
  end

  dram_open_row_table #(
    .NUM_OF_BANKS (NUM_OF_BANKS),
    .ROW_W        (ROW_W)
  ) u_table (
    .clk          (clk),
    .rst          (rst),
    .lookup_bank  (bank_d),
    .lookup_valid (lk_valid),
    .lookup_row   (lk_row),
    .wr_en        (accept),
    .wr_bank      (bank_d),
    .wr_row       (row_d),
    .pre_valid    (pre_valid),
    .pre_all      (pre_all),
    .pre_bank     (pre_bank)
  );

  // Row-buffer classification against the (precharge-adjusted) table entry.
  always_comb begin
    state_d = ROW_EMPTY;
    prev_d  = '0;
    if (lk_valid) begin
      if (lk_row == row_d) begin
        state_d = ROW_HIT;
      end else begin
        state_d = ROW_MISS;
        prev_d  = lk_row;
      end
    end
  end

  // Output register: load on accept, drop valid once consumed, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      state_q     <= ROW_EMPTY;
      prev_q      <= '0;
      addr_err_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      bank_q      <= bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      state_q     <= state_d;
      prev_q      <= prev_d;
      addr_err_q  <= addr_err_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.bank_id   = bank_q;
  assign bus.row_id    = row_q;
  assign bus.col_id    = col_q;
  assign bus.row_state = state_q;
  assign bus.prev_row  = prev_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_dram_addr_mapper.sv
// Directed testbench for dram_addr_mapper: field splits in every mode,
// row-state classification, backpressure, precharge, streaming, reset and
// the address-range flag on a wider-address instance.
module tb_dram_addr_mapper;
  import dram_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] map_mode;
  logic       pre_valid;
  logic       pre_all;
  logic [2:0] pre_bank;

  int checks = 0;
  int errors = 0;

  dram_addr_mapper_if #(.ADDR_WIDTH(13), .BANK_W(3), .ROW_W(7), .COL_W(3)) bus ();
  dram_addr_mapper_if #(.ADDR_WIDTH(16), .BANK_W(3), .ROW_W(7), .COL_W(3)) bus_w ();

  dram_addr_mapper #(
    .ADDR_WIDTH(13), .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .map_mode  (map_mode),
    .pre_valid (pre_valid),
    .pre_all   (pre_all),
    .pre_bank  (pre_bank),
    .bus       (bus)
  );

  dram_addr_mapper #(
    .ADDR_WIDTH(16), .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .NUM_OF_COLS(8)
  ) u_dut_wide (
    .clk       (clk),
    .rst       (rst),
    .map_mode  (map_mode),
    .pre_valid (pre_valid),
    .pre_all   (pre_all),
    .pre_bank  (pre_bank),
    .bus       (bus_w)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [12:0] addr, input logic [1:0] mode);
    bus.req_valid      = 1'b1;
    bus.l2_req_address = addr;
    map_mode           = mode;
    tick();
    bus.req_valid      = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int bank, input int row, input int col,
                            input row_state_e st, input int prev);
    check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".bank"},  32'(bus.bank_id),   32'(bank));
    check({tag, ".row"},   32'(bus.row_id),    32'(row));
    check({tag, ".col"},   32'(bus.col_id),    32'(col));
    check({tag, ".state"}, 32'(bus.row_state), 32'(st));
    check({tag, ".prev"},  32'(bus.prev_row),  32'(prev));
    check({tag, ".err"},   32'(bus.addr_err),  32'd0);
  endtask

  initial begin
    rst                  = 1'b1;
    map_mode             = MAP_BRC;
    pre_valid            = 1'b0;
    pre_all              = 1'b0;
    pre_bank             = '0;
    bus.req_valid        = 1'b0;
    bus.l2_req_address   = '0;
    bus.out_ready        = 1'b1;
    bus_w.req_valid      = 1'b0;
    bus_w.l2_req_address = '0;
    bus_w.out_ready      = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.req_ready", 32'(bus.req_ready), 32'd1);
    check("rst.bank",      32'(bus.bank_id),   32'd0);
    check("rst.row",       32'(bus.row_id),    32'd0);
    check("rst.col",       32'(bus.col_id),    32'd0);
    check("rst.state",     32'(bus.row_state), 32'd0);
    check("rst.prev",      32'(bus.prev_row),  32'd0);
    check("rst.err",       32'(bus.addr_err),  32'd0);
    rst = 1'b0;
    tick();

    // Mode 0 split and classification
    send(13'h1C2D, MAP_BRC); expect_out("m0.empty", 7, 5, 5, ROW_EMPTY, 0);
    send(13'h1C2D, MAP_BRC); expect_out("m0.hit",   7, 5, 5, ROW_HIT,   0);
    send(13'h1C35, MAP_BRC); expect_out("m0.miss",  7, 6, 5, ROW_MISS,  5);

    // Modes 1, 2, 3
    send(13'h0048, 2'd1); expect_out("m1", 1, 1, 0, ROW_EMPTY, 0);
    send(13'h0408, 2'd2); expect_out("m2", 0, 1, 0, ROW_EMPTY, 0);
    send(13'h1C2D, 2'd3); expect_out("m3", 7, 5, 5, ROW_MISS,  6);
    tick();
    check("drain.out_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: bank 0 holds row 1, so 0x0010 (row 2) is a MISS
    bus.out_ready      = 1'b0;
    bus.req_valid      = 1'b1;
    bus.l2_req_address = 13'h0010;
    map_mode           = MAP_BRC;
    #1;
    check("bp.ready0", 32'(bus.req_ready), 32'd1);
    tick();
    bus.l2_req_address = 13'h0018;
    for (int i = 0; i < 4; i++) begin
      check("bp.stall_ready", 32'(bus.req_ready), 32'd0);
      check("bp.stall_valid", 32'(bus.out_valid), 32'd1);
      check("bp.stall_row",   32'(bus.row_id),    32'd2);
      check("bp.stall_state", 32'(bus.row_state), 32'(ROW_MISS));
      check("bp.stall_prev",  32'(bus.prev_row),  32'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    expect_out("bp.next", 0, 3, 0, ROW_MISS, 2);

    // Precharge of the same bank in the accept cycle -> EMPTY
    send(13'h1C2D, MAP_BRC); expect_out("pre.open", 7, 5, 5, ROW_HIT, 0);
    pre_valid = 1'b1;
    pre_bank  = 3'd7;
    send(13'h1C2D, MAP_BRC); expect_out("pre.same", 7, 5, 5, ROW_EMPTY, 0);
    pre_bank  = 3'd1;
    send(13'h1C2D, MAP_BRC); expect_out("pre.other", 7, 5, 5, ROW_HIT, 0);
    pre_valid = 1'b0;
    send(13'h0048, MAP_RBC); expect_out("pre.closed", 1, 1, 0, ROW_EMPTY, 0);

    // Precharge-all after opening every bank
    for (int b = 0; b < 8; b++) send(13'((b << 10) | (b << 3)), MAP_BRC);
    pre_valid = 1'b1;
    pre_all   = 1'b1;
    tick();
    pre_valid = 1'b0;
    pre_all   = 1'b0;
    for (int b = 0; b < 8; b++) begin
      send(13'((b << 10) | ((b + 1) << 3)), MAP_BRC);
      check("preall.bank",  32'(bus.bank_id),   32'(b));
      check("preall.state", 32'(bus.row_state), 32'(ROW_EMPTY));
    end

    // Streaming, one request per cycle on bank 0
    pre_valid = 1'b1;
    pre_bank  = 3'd0;
    tick();
    pre_valid          = 1'b0;
    bus.req_valid      = 1'b1;
    bus.l2_req_address = 13'h0008;
    tick();
    expect_out("st.empty", 0, 1, 0, ROW_EMPTY, 0);
    check("st.ready", 32'(bus.req_ready), 32'd1);
    tick();
    expect_out("st.hit", 0, 1, 0, ROW_HIT, 0);
    bus.l2_req_address = 13'h0010;
    tick();
    expect_out("st.miss", 0, 2, 0, ROW_MISS, 1);
    bus.req_valid = 1'b0;
    tick();

    // Reset while an output is held
    bus.out_ready = 1'b0;
    send(13'h1C2D, MAP_BRC);
    check("mid.held_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid.out_valid", 32'(bus.out_valid), 32'd0);
    check("mid.req_ready", 32'(bus.req_ready), 32'd1);
    bus.out_ready = 1'b1;
    send(13'h1C2D, MAP_BRC); expect_out("mid.reaccess", 7, 5, 5, ROW_EMPTY, 0);

    // Address-range flag on the 16-bit instance
    bus_w.req_valid      = 1'b1;
    bus_w.l2_req_address = 16'h8000;
    map_mode             = MAP_BRC;
    tick();
    check("wide.err_set",  32'(bus_w.addr_err),  32'd1);
    check("wide.err_bank", 32'(bus_w.bank_id),   32'd0);
    check("wide.err_row",  32'(bus_w.row_id),    32'd0);
    bus_w.l2_req_address = 16'h1C2D;
    tick();
    bus_w.req_valid = 1'b0;
    check("wide.err_clr", 32'(bus_w.addr_err),  32'd0);
    check("wide.bank",    32'(bus_w.bank_id),   32'd7);
    check("wide.row",     32'(bus_w.row_id),    32'd5);
    check("wide.state",   32'(bus_w.row_state), 32'(ROW_EMPTY));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_addr_mapper.md
Name: dram_addr_mapper

Overview:
- Parametrised, pipelined successor to the flat address translator.
- Splits an L2 request address into bank/row/col using a selectable mapping mode.
- Tracks the open row per bank and classifies each request as row EMPTY, HIT or MISS (conflict).
- Sits between the L2 request interface and the DRAM command scheduler, with valid/ready handshakes on both sides.

Parameters:
- ADDR_WIDTH, 13, request address width.
- NUM_OF_BANKS, 8, bank count; power of two, >=2.
- NUM_OF_ROWS, 128, rows per bank; power of two; NUM_OF_ROWS >= NUM_OF_BANKS.
- NUM_OF_COLS, 8, columns per row; power of two.
- Derived: BANK_W=$clog2(NUM_OF_BANKS), ROW_W=$clog2(NUM_OF_ROWS), COL_W=$clog2(NUM_OF_COLS), USED_W=BANK_W+ROW_W+COL_W. Required: USED_W <= ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- map_mode  in  2  0=bank:row:col, 1=row:bank:col, 2=XOR-hashed bank, 3=treated as 0.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid&&req_ready.
- l2_req_address  in  ADDR_WIDTH  request address.
- pre_valid  in  1  precharge notification from the scheduler (bank closed).
- pre_all  in  1  with pre_valid: close all banks.
- pre_bank  in  BANK_W  bank being closed.
- out_valid  out  1  decoded request available.
- out_ready  in  1  downstream accepts the output.
- bank_id  out  BANK_W  decoded bank.
- row_id  out  ROW_W  decoded row.
- col_id  out  COL_W  decoded column.
- row_state  out  2  0=EMPTY, 1=HIT, 2=MISS.
- prev_row  out  ROW_W  row open before this request; valid only when row_state=MISS, otherwise 0.
- addr_err  out  1  address bits [ADDR_WIDTH-1:USED_W] non-zero.

Behaviour:
- Reset: req_ready=1 after reset; out_valid=0; bank_id/row_id/col_id/prev_row/row_state/addr_err=0; all open-row valid bits cleared.
- Handshake:
  - req_ready = !out_valid || out_ready, combinational.
  - Latency 1 cycle: an accepted request appears at the outputs the next cycle with out_valid=1.
  - Outputs hold stable while out_valid && !out_ready.
  - Back-to-back throughput is 1 request per cycle.
- map_mode is sampled only on acceptance; changing it does not affect a request already held.
- Field extraction:
  - col = addr[COL_W-1:0] in every mode.
  - Mode 0: row = addr[COL_W +: ROW_W], bank = addr[COL_W+ROW_W +: BANK_W].
  - Mode 1: bank = addr[COL_W +: BANK_W], row = addr[COL_W+BANK_W +: ROW_W].
  - Mode 2: fields as mode 0, then bank = bank_raw XOR row[BANK_W-1:0]. The row is unchanged.
- Open-row table: one entry per bank, each holding {valid, row[ROW_W-1:0]}.
- Classification, made on acceptance against the table (after any same-cycle precharge):
  - !valid -> EMPTY.
  - valid && row match -> HIT.
  - Otherwise MISS, with prev_row = the stored row.
- Table update on acceptance: entry[bank] <= {1, row}.
- Precharge:
  - pre_valid clears entry[pre_bank].valid.
  - pre_valid && pre_all clears every entry.
- Same-cycle precharge and accepted request:
  - Same bank: the precharge applies first, so the request is EMPTY and the entry ends up {1, new row}.
  - Different bank: the two are independent.
- Two consecutive requests to one bank: the second sees the table as updated by the first (no stale read). The update is visible the next cycle.
- addr_err is informational only; the request still decodes and updates the table.
- rst mid-operation drops any held output and clears the table.

Decomposition:
- Shared package dram_pkg holds:
  - row-state enum: ROW_EMPTY=2'd0, ROW_HIT=2'd1, ROW_MISS=2'd2;
  - map-mode constants: MAP_BRC=0, MAP_RBC=1, MAP_XOR=2.
- One sub-module, dram_open_row_table:
  - per-bank valid/row storage;
  - lookup returning valid/row, write port, precharge/precharge-all port;
  - precharge-before-lookup ordering implemented inside it.
- Field extraction is combinational logic in the top module.

Test Plan:
- Mode 0 field split: 0x1C2D -> bank 7, row 5, col 5, EMPTY. Repeat 0x1C2D -> HIT. Then 0x1C35 -> bank 7, row 6, MISS, prev_row 5.
- Mode 1 and mode 2 split:
  - Mode 1, 0x0048 -> bank 1, row 1, col 0.
  - Mode 2, 0x0408 -> bank 0 (1^1), row 1, col 0.
  - Mode 3, 0x1C2D -> same as mode 0.
- Backpressure: out_ready=0 with req_valid=1 for 5 cycles:
  - exactly one request is accepted, and req_ready=0 from the next cycle;
  - outputs stay stable;
  - after out_ready=1, the next request is accepted in the same cycle.
- Precharge:
  - Open bank 7 row 5, then pre_valid with pre_bank=7 in the same cycle as request 0x1C2D -> EMPTY.
  - pre_all=1 after opening banks 0-7 -> the next access to each bank is EMPTY.
- Streaming 1/cycle: 0x0008, 0x0008, 0x0010 in consecutive cycles (bank 0) -> EMPTY, HIT, MISS with prev_row 1.
- Reset mid-operation: assert rst with out_valid=1 -> the next cycle shows out_valid=0, req_ready=1, and the re-access to 0x1C2D is EMPTY. With ADDR_WIDTH=16, address 0x8000 -> addr_err=1.
